filter_packer: RTL

- Sequences the output of the 4-lane valid-word compaction filter into dense 4-word lines for the downstream update writer.
- Accepts one filter bundle per cycle under a valid/ready handshake and keeps up to 3 leftover words as residue.
- Emits only full lines, except for the final partial line flushed at end-of-input.
- Provides the backpressure the filter itself lacks; the upstream issue controller gates filter input with in_ready.

---
 rtl/filter_pkg.sv | 34 +++
 rtl/lane_pack4.sv | 55 +++++
 rtl/filter_packer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : filter_pkg
// Description : Shared constants and types for the filter line packer: lane
//               count, word and bundle types, packer FSM states and a
//               prefix-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package filter_pkg;

    localparam int LANES         = 4;
    localparam int DEFAULT_WIDTH = 64;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

    // One filter output bundle; word[0] is lane 0.
    typedef struct packed {
        logic [LANES-1:0]  mask;
        word_t [LANES-1:0] word;
        logic              last;
    } bundle_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pack_state_e;

    // Contiguous lane mask covering lanes 0..n-1.
    function automatic logic [LANES-1:0] prefix_mask(input logic [1:0] n);
        return LANES'((32'd1 << n) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_pack4.sv
`default_nettype none
// ============================================================================
// Module      : lane_pack4
// Description : Combinational merge of up to 3 residue words with the valid
//               lanes of a 4-lane bundle. Produces the merged sequence S
//               (first four words as a candidate line), its length t, and the
//               residue/count left after removing a full line when t >= 4.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_pack4
    import filter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [LANES-2:0][WIDTH-1:0] res_word,
    input  logic [1:0]                  res_cnt,
    input  logic [LANES-1:0]            in_mask,
    input  logic [LANES-1:0][WIDTH-1:0] in_word,
    output logic [LANES-1:0][WIDTH-1:0] line_word,
    output logic [2:0]                  total,
    output logic [LANES-2:0][WIDTH-1:0] next_res_word,
    output logic [1:0]                  next_cnt
);

    logic [6:0][WIDTH-1:0] w_seq;
    logic [2:0]            w_pos;

    // Build S: residue first, then valid lanes in ascending order; slots past t stay zero.
    always_comb begin
        w_seq = '0;
        w_pos = {1'b0, res_cnt};
        for (int i = 0; i < LANES - 1; i++) begin
            if (i < int'(res_cnt)) begin
                w_seq[i] = res_word[i];
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (in_mask[l]) begin
                w_seq[w_pos] = in_word[l];
                w_pos        = w_pos + 3'd1;
            end
        end
        total     = w_pos;
        line_word = w_seq[3:0];
        if (w_pos >= 3'd4) begin
            next_res_word = w_seq[6:4];
            next_cnt      = 2'(w_pos - 3'd4);
        end else begin
            next_res_word = w_seq[2:0];
            next_cnt      = w_pos[1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/filter_packer.sv
`default_nettype none
// ============================================================================
// Module      : filter_packer
// Description : Packs 4-lane filter bundles into dense 4-word lines with a
//               one-line output register, residue of up to 3 words, and a
//               FLUSH state that emits the final partial line at end-of-input.
//               Optional statistics counters under FILTER_PACKER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_packer
    import filter_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAT_W = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES-1:0]            in_mask,
    input  logic [LANES-1:0][WIDTH-1:0] in_word,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES-1:0]            out_mask,
    output logic [LANES-1:0][WIDTH-1:0] out_word,
    output logic                        out_last,
    output logic [STAT_W-1:0]           stat_words,
    output logic [STAT_W-1:0]           stat_lines
);

    logic [1:0]                  r_rst_sync;
    logic                        w_rst_n;
    pack_state_e                 r_state,    w_state_nxt;
    logic [1:0]                  r_cnt,      w_cnt_nxt;
    logic [LANES-2:0][WIDTH-1:0] r_res,      w_res_nxt;
    logic                        r_out_valid, w_ov_nxt;
    logic [LANES-1:0]            r_out_mask,  w_om_nxt;
    logic [LANES-1:0][WIDTH-1:0] r_out_word,  w_ow_nxt;
    logic                        r_out_last,  w_ol_nxt;
    logic                        w_free;
    logic                        w_accept;
    logic [LANES-1:0][WIDTH-1:0] w_line;
    logic [2:0]                  w_total;
    logic [LANES-2:0][WIDTH-1:0] w_pack_res;
    logic [1:0]                  w_pack_cnt;

    // Reset asserts asynchronously and releases two clocks later, synchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_free    = !r_out_valid || out_ready;
    assign in_ready  = w_rst_n && (r_state == RUN) && w_free;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_mask  = r_out_mask;
    assign out_word  = r_out_word;
    assign out_last  = r_out_last;

    lane_pack4 #(.WIDTH(WIDTH)) u_lane_pack4 (
        .res_word      (r_res),
        .res_cnt       (r_cnt),
        .in_mask       (in_mask),
        .in_word       (in_word),
        .line_word     (w_line),
        .total         (w_total),
        .next_res_word (w_pack_res),
        .next_cnt      (w_pack_cnt)
    );

    // Next-state and output-register load decisions for RUN/FLUSH.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_res_nxt   = r_res;
        w_ov_nxt    = r_out_valid && !out_ready;
        w_om_nxt    = r_out_mask;
        w_ow_nxt    = r_out_word;
        w_ol_nxt    = r_out_last;
        case (r_state)
            RUN: begin
                if (w_accept) begin
                    w_cnt_nxt = w_pack_cnt;
                    w_res_nxt = w_pack_res;
                    if (w_total >= 3'd4) begin
                        w_ov_nxt = 1'b1;
                        w_om_nxt = '1;
                        w_ow_nxt = w_line;
                        w_ol_nxt = 1'b0;
                    end
                    if (in_last) begin
                        if (w_pack_cnt != 2'd0) begin
                            w_state_nxt = FLUSH;
                        end else if (w_total >= 3'd4) begin
                            w_ol_nxt = 1'b1;
                        end else begin
                            // Nothing to carry the end-of-stream flag: emit an empty marker line.
                            w_ov_nxt = 1'b1;
                            w_om_nxt = '0;
                            w_ow_nxt = '0;
                            w_ol_nxt = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (w_free) begin
                    w_ov_nxt = 1'b1;
                    w_om_nxt = prefix_mask(r_cnt);
                    w_ow_nxt = '0;
                    for (int l = 0; l < LANES - 1; l++) begin
                        if (l < int'(r_cnt)) begin
                            w_ow_nxt[l] = r_res[l];
                        end
                    end
                    w_ol_nxt    = 1'b1;
                    w_cnt_nxt   = 2'd0;
                    w_res_nxt   = '0;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // State, residue and output line registers.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= RUN;
            r_cnt       <= 2'd0;
            r_res       <= '0;
            r_out_valid <= 1'b0;
            r_out_mask  <= '0;
            r_out_word  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_res       <= w_res_nxt;
            r_out_valid <= w_ov_nxt;
            r_out_mask  <= w_om_nxt;
            r_out_word  <= w_ow_nxt;
            r_out_last  <= w_ol_nxt;
        end
    end

`ifdef FILTER_PACKER_STATS_EN
    logic [STAT_W-1:0] r_stat_words;
    logic [STAT_W-1:0] r_stat_lines;

    // Accepted-word and emitted-line counters, wrapping at 2^STAT_W.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_stat_words <= '0;
            r_stat_lines <= '0;
        end else begin
            if (w_accept) begin
                r_stat_words <= r_stat_words + STAT_W'(w_total - {1'b0, r_cnt});
            end
            if (r_out_valid && out_ready) begin
                r_stat_lines <= r_stat_lines + STAT_W'(1);
            end
        end
    end
    assign stat_words = r_stat_words;
    assign stat_lines = r_stat_lines;
`else
    assign stat_words = '0;
    assign stat_lines = '0;
`endif

endmodule
`default_nettype wire
